cache_pmem_arbiter: RTL and testbench

- Shares the single 64-bit physical-memory port between I-cache and D-cache line-miss traffic, one 256-bit line per transaction.
- Each cache side presents a line-level request. The block grants one side and sequences the line as a BURST_LEN-beat read or write burst on pmem.
- Returns the line to the granted cache with a one-cycle resp.
- Sits inside cache_sys, between the two caches and the pmem_* top-level ports.

---
 rtl/cache_pmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_cache_pmem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_pmem_arbiter.sv
// Shares one 64-bit pmem port between I-cache and D-cache line misses, one BURST_LEN-beat burst per line.
// Define ARB_RR_EN for round-robin between simultaneous requesters; default is fixed D-over-I priority.
module cache_pmem_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int BEAT_W    = 64,
  localparam int LINE_W   = BURST_LEN * BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  // IDLE: arbitrate | RD: read burst | WR: write burst | DONE: one-cycle resp to granted side
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [31:0]         addr_q, addr_d;
  logic [1:0]          gnt_q, gnt_d;    // {D, I}
  logic [1:0]          mask_q, mask_d;  // {D, I}
  logic                last_q, last_d;  // 1 = D was granted last
  logic [1:0]          elig;
  logic                pick_d;
  logic                last_beat;

  assign elig      = {d_read | d_write, i_read} & ~mask_q;
  assign last_beat = (cnt_q == CNT_W'(BURST_LEN - 1));

`ifdef ARB_RR_EN
  assign pick_d = elig[1] & (~elig[0] | ~last_q);
`else
  assign pick_d = elig[1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      gnt_q   <= '0;
      mask_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      gnt_q   <= gnt_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    addr_d  = addr_q;
    gnt_d   = gnt_q;
    mask_d  = mask_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        mask_d = '0;
        if (elig != 2'b00) begin
          cnt_d = '0;
          if (pick_d) begin
            gnt_d  = 2'b10;
            addr_d = {d_address[31:5], 5'b0};
            // A simultaneous read+write is treated as a writeback.
            if (d_write) begin
              line_d  = d_wdata;
              state_d = WR;
            end else begin
              state_d = RD;
            end
          end else begin
            gnt_d   = 2'b01;
            addr_d  = {i_address[31:5], 5'b0};
            state_d = RD;
          end
        end
      end
      RD: begin
        if (pmem_resp) begin
          line_d[cnt_q*BEAT_W +: BEAT_W] = pmem_rdata;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) state_d = DONE;
        end
      end
      WR: begin
        if (pmem_resp) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) state_d = DONE;
        end
      end
      DONE: begin
        // Mask the served side for one IDLE cycle so a registered deassert is not re-granted.
        mask_d  = gnt_q;
        last_d  = gnt_q[1];
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pmem_read    = (state_q == RD);
  assign pmem_write   = (state_q == WR);
  assign pmem_address = (pmem_read | pmem_write) ? addr_q : '0;
  assign pmem_wdata   = pmem_write ? line_q[cnt_q*BEAT_W +: BEAT_W] : '0;
  assign i_resp       = (state_q == DONE) & gnt_q[0];
  assign d_resp       = (state_q == DONE) & gnt_q[1];
  assign i_rdata      = line_q;
  assign d_rdata      = line_q;

  // Offset bits of the line address are dropped; last_grant only steers round-robin builds.
  logic unused_bits;
  assign unused_bits = ^{i_address[4:0], d_address[4:0], last_q};

`ifndef SYNTHESIS
  a_dreq_excl: assert property (@(posedge clk) disable iff (!rst)
    (state_q == IDLE) |-> !(d_read && d_write))
    else $error("d_read and d_write asserted together");
`endif

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// Bench for cache_pmem_arbiter: vector table plus hand sequences, with a pmem responder and a
// queue of expected line transactions in service order.
module tb_cache_pmem_arbiter;
  localparam int BL = 4;
  localparam int BW = 64;
  localparam int LW = BL * BW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_read = 1'b0;
  logic [31:0]   i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [31:0]   d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_address;
  logic [BW-1:0] pmem_wdata;
  logic [BW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  always #5 clk = ~clk;

  cache_pmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    bit            side_d;
    bit            is_wr;
    logic [31:0]   addr;
    logic [LW-1:0] line;
  } txn_t;

  typedef struct {
    bit          ir, dr, dw;
    logic [31:0] ia, da;
    logic [31:0] exp_ia, exp_da;
    logic [31:0] wtag;
    int          gap;
  } vec_t;

  txn_t          sb[$];
  vec_t          vt[6];
  int            tests = 0, fails = 0;
  int            cyc = 0, gap = 0, gc = 0, bi = 0;
  int            bursts = 0, n_pushed = 0, wr_beats = 0, resp_cyc = 0;
  bit            mdl_last_d = 0, hold_i = 0, hold_pend = 0;
  logic [LW-1:0] last_rdata = '0;

  function automatic logic [BW-1:0] beat(int k, int s);
    logic [7:0] b;
    b = 8'((k + 1) * 17);
    return {8{b}} ^ {32'(s), 32'(s)};
  endfunction

  function automatic logic [LW-1:0] line_of(int s);
    logic [LW-1:0] l;
    for (int k = 0; k < BL; k++) l[k*BW +: BW] = beat(k, s);
    return l;
  endfunction

  task automatic check(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(bit side_d, bit is_wr, logic [31:0] addr, logic [LW-1:0] wl);
    txn_t t;
    t.side_d = side_d;
    t.is_wr  = is_wr;
    t.addr   = addr;
    t.line   = is_wr ? wl : line_of(n_pushed);
    n_pushed++;
    mdl_last_d = side_d;
    sb.push_back(t);
  endtask

  // One cycle: monitor responses, then act as pmem for the cycle that follows.
  task automatic step();
    txn_t t;
    @(negedge clk);
    cyc++;
    if (hold_pend) begin i_read = 1'b0; hold_pend = 1'b0; end
    check("rw_exclusive", LW'(pmem_read && pmem_write), '0);
    if (i_resp && d_resp) begin
      tests++; fails++;
      $display("FAIL resp_exclusive: i_resp=1 d_resp=1, required at most one");
    end
    if (i_resp || d_resp) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_resp: i_resp=%0b d_resp=%0b with nothing outstanding", i_resp, d_resp);
      end else begin
        t = sb.pop_front();
        check("resp_side", LW'(d_resp), LW'(t.side_d));
        if (!t.is_wr) check("rdata", t.side_d ? d_rdata : i_rdata, t.line);
        resp_cyc   = cyc;
        last_rdata = i_rdata;
      end
      if (d_resp) begin d_read = 1'b0; d_write = 1'b0; end
      if (i_resp) begin
        if (hold_i) begin hold_pend = 1'b1; hold_i = 1'b0; end
        else i_read = 1'b0;
      end
    end
    if (pmem_resp) begin
      if (bi == BL - 1) bursts++;
      bi++;
      gc = 0;
    end
    pmem_resp = 1'b0;
    if (pmem_read || pmem_write) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_burst: pmem_address=%h with nothing outstanding", pmem_address);
      end else begin
        check("pmem_addr", LW'(pmem_address), LW'(sb[0].addr));
        check("pmem_dir_write", LW'(pmem_write), LW'(sb[0].is_wr));
        if (gc >= gap) begin
          if (pmem_write) begin
            check("pmem_wdata", LW'(pmem_wdata), LW'(sb[0].line[bi*BW +: BW]));
            wr_beats++;
          end
          pmem_rdata = beat(bi, bursts);
          pmem_resp  = 1'b1;
        end else begin
          gc++;
        end
      end
    end else begin
      bi = 0;
      gc = 0;
    end
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin step(); n++; end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: %0d transactions pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    vec_t          x;
    logic [LW-1:0] wl;
    bit            first_d;
    int            t0, b0, n;

    vt[0] = '{ir:1, dr:0, dw:0, ia:32'h0000_1234, da:32'h0, exp_ia:32'h0000_1220, exp_da:32'h0, wtag:32'h0, gap:0};
    vt[1] = '{ir:0, dr:0, dw:1, ia:32'h0, da:32'h8000_0040, exp_ia:32'h0, exp_da:32'h8000_0040, wtag:32'h0, gap:0};
    vt[2] = '{ir:1, dr:1, dw:0, ia:32'h0000_2000, da:32'h0000_3018, exp_ia:32'h0000_2000, exp_da:32'h0000_3000, wtag:32'h0, gap:0};
    vt[3] = '{ir:0, dr:1, dw:0, ia:32'h0, da:32'hFFFF_FFFF, exp_ia:32'h0, exp_da:32'hFFFF_FFE0, wtag:32'h0, gap:2};
    vt[4] = '{ir:1, dr:0, dw:1, ia:32'h0000_001F, da:32'h0000_0040, exp_ia:32'h0, exp_da:32'h0000_0040, wtag:32'h7, gap:1};
    vt[5] = '{ir:0, dr:1, dw:0, ia:32'h0, da:32'hABCD_EF7F, exp_ia:32'h0, exp_da:32'hABCD_EF60, wtag:32'h0, gap:0};

    // Reset state
    repeat (2) step();
    check("rst_pmem_read", LW'(pmem_read), '0);
    check("rst_pmem_write", LW'(pmem_write), '0);
    check("rst_pmem_address", LW'(pmem_address), '0);
    check("rst_pmem_wdata", LW'(pmem_wdata), '0);
    check("rst_i_resp", LW'(i_resp), '0);
    check("rst_d_resp", LW'(d_resp), '0);
    check("rst_i_rdata", i_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    rst = 1'b1;
    repeat (2) step();

    for (int v = 0; v < 6; v++) begin
      x = vt[v];
      for (int k = 0; k < BL; k++) wl[k*BW +: BW] = BW'(k + 1) | (BW'(x.wtag) << 32);
      gap = x.gap;
`ifdef ARB_RR_EN
      first_d = !mdl_last_d;
`else
      first_d = 1'b1;
`endif
      if (x.ir && (x.dr || x.dw)) begin
        if (first_d) begin
          push(1'b1, x.dw, x.exp_da, wl);
          push(1'b0, 1'b0, x.exp_ia, '0);
        end else begin
          push(1'b0, 1'b0, x.exp_ia, '0);
          push(1'b1, x.dw, x.exp_da, wl);
        end
      end else if (x.ir) begin
        push(1'b0, 1'b0, x.exp_ia, '0);
      end else begin
        push(1'b1, x.dw, x.exp_da, wl);
      end
      i_read = x.ir; i_address = x.ia;
      d_read = x.dr; d_write = x.dw; d_address = x.da; d_wdata = wl;
      t0 = cyc;
      wr_beats = 0;
      drain($sformatf("vec%0d", v));
      if (v == 0) begin
        check("i_read_latency", LW'(resp_cyc - t0), LW'(5));
        check("i_read_line", last_rdata,
              {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
      end
      if (v == 1) check("d_write_beats", LW'(wr_beats), LW'(4));
      repeat (2) step();
    end

    // I held one cycle past its resp while D waits: D must get the masked IDLE cycle.
    gap = 0;
    push(1'b0, 1'b0, 32'h0000_0500, '0);
    hold_i = 1'b1; i_read = 1'b1; i_address = 32'h0000_051C;
    repeat (2) step();
    push(1'b1, 1'b0, 32'h0000_0600, '0);
    d_read = 1'b1; d_address = 32'h0000_0610;
    drain("hold_then_d");
    repeat (2) step();

    // I held one extra cycle with nothing else pending: exactly one burst.
    b0 = bursts;
    push(1'b0, 1'b0, 32'h0000_0900, '0);
    hold_i = 1'b1; i_read = 1'b1; i_address = 32'h0000_0908;
    drain("hold_alone");
    repeat (8) step();
    check("no_dup_burst", LW'(bursts - b0), LW'(1));

    // Reset after the second read beat.
    push(1'b0, 1'b0, 32'h0000_0700, '0);
    i_read = 1'b1; i_address = 32'h0000_0704;
    n = 0;
    while (bi < 2 && n < 50) begin step(); n++; end
    check("reach_beat2", LW'(bi >= 2), LW'(1));
    #2 rst = 1'b0;
    #1;
    check("midrst_pmem_read", LW'(pmem_read), '0);
    check("midrst_pmem_write", LW'(pmem_write), '0);
    check("midrst_pmem_address", LW'(pmem_address), '0);
    check("midrst_i_resp", LW'(i_resp), '0);
    check("midrst_i_rdata", i_rdata, '0);
    sb.delete();
    i_read = 1'b0; pmem_resp = 1'b0; bi = 0; gc = 0;
    n_pushed = bursts; mdl_last_d = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    push(1'b0, 1'b0, 32'h0000_0700, '0);
    i_read = 1'b1; i_address = 32'h0000_0704;
    drain("after_reset");
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
